dii_ring_gateway_demux_n: RTL and testbench

Parametrised gateway demultiplexer for the debug-interconnect (DII) ring. It inspects the destination field of each packet header arriving from the ring and steers the whole packet (a worm) to one of three places:
- the local node;
- one of `NUM_EXT` external subnet ports;
- onward along the ring.

Compared with the single-external-port gateway, it adds multiple external ports, an optional registered output slice per port, and a drop path for unroutable packets. It sits between the ring segment and the subnet bridges in each gateway router.

---
 rtl/dii_gateway_package.sv | 29 ++
 rtl/dii_package.sv | 10 +
 rtl/dii_flit_reg_slice.sv | 29 ++
 rtl/dii_ring_gateway_demux_n.sv | 151 +++++++++++++++
 tb/tb_dii_ring_gateway_demux_n.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dii_gateway_package.sv
// Types and helpers shared by the DII gateway routing blocks.
package dii_gateway_package;

    // Destination chosen for a worm at its header flit
    typedef enum logic [1:0] {
        ROUTE_LOCAL,
        ROUTE_EXT,
        ROUTE_RING,
        ROUTE_DROP
    } route_t;

    // Worm tracking state of the demultiplexer
    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_t;

    // Fixed output port numbering; external ports follow from PORT_EXT0 upward
    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_RING  = 1;
    localparam int unsigned PORT_EXT0  = 2;

    // Width of the external port selector taken from the subnet field
    function automatic int unsigned ext_sel_bits(input int unsigned num_ext);
        return (num_ext <= 32'd1) ? 32'd1 : 32'($clog2(num_ext));
    endfunction

endpackage

// File: rtl/dii_package.sv
// Common DII flit type shared by every block on the debug interconnect ring.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/dii_flit_reg_slice.sv
// One-entry valid/ready pipeline register for DII flits.
// Accepts a new flit whenever empty or being drained, so it sustains one
// flit per cycle under continuous downstream ready.
module dii_flit_reg_slice
    import dii_package::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  dii_flit up,
    output logic    up_ready,
    output dii_flit down,
    input  logic    down_ready
);

    dii_flit held;

    assign up_ready = !held.valid || down_ready;
    assign down     = held;

    // Load the slot when it is free or its current flit leaves this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (up_ready) begin
            held <= up;
        end
    end

endmodule

// File: rtl/dii_ring_gateway_demux_n.sv
// DII ring gateway demultiplexer with NUM_EXT external subnet ports.
// Header flits are decoded to local / external / ring / drop; the route is
// held for the rest of the worm. Each output optionally has a register slice.
module dii_ring_gateway_demux_n
    import dii_package::*;
    import dii_gateway_package::*;
#(
    parameter int unsigned SUBNET_BITS  = 6,
    parameter int unsigned LOCAL_SUBNET = 0,
    parameter int unsigned NUM_EXT      = 2,
    parameter int unsigned OUT_REG      = 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic    [15:0]        id,
    input  dii_flit               in_ring,
    output logic                  in_ring_ready,
    output dii_flit               out_local,
    input  logic                  out_local_ready,
    output dii_flit [NUM_EXT-1:0] out_ext,
    input  logic    [NUM_EXT-1:0] out_ext_ready,
    output dii_flit               out_ring,
    input  logic                  out_ring_ready,
    output logic                  drop_pkt
);

    localparam int unsigned SEL_BITS  = ext_sel_bits(NUM_EXT);
    localparam int unsigned NUM_PORTS = NUM_EXT + 2;

    // Header decode
    logic [SUBNET_BITS-1:0] subnet;
    logic [SEL_BITS-1:0]    ext_idx_dec;
    route_t                 route_dec;

    // Worm state
    state_t                 state;
    route_t                 route_q;
    logic [SEL_BITS-1:0]    ext_idx_q;

    // Route in effect this cycle
    route_t                 route;
    logic [SEL_BITS-1:0]    ext_idx;

    // Per-port steering, index order: local, ring, ext[0..NUM_EXT-1]
    logic [NUM_EXT-1:0]      sel_ext;
    logic                    sel_local;
    logic                    sel_ring;
    logic [NUM_PORTS-1:0]    sel;
    dii_flit [NUM_PORTS-1:0] port_up;
    dii_flit [NUM_PORTS-1:0] port_down;
    logic [NUM_PORTS-1:0]    port_up_ready;
    logic [NUM_PORTS-1:0]    port_down_ready;

    logic accept;

    assign subnet      = in_ring.data[15 -: SUBNET_BITS];
    assign ext_idx_dec = in_ring.data[16-SUBNET_BITS +: SEL_BITS];

    // Decode the destination of a header; local match wins over subnet match
    always_comb begin
        route_dec = ROUTE_RING;
        if (in_ring.data == id) begin
            route_dec = ROUTE_LOCAL;
        end else if (subnet != SUBNET_BITS'(LOCAL_SUBNET)) begin
            route_dec = (32'(ext_idx_dec) < NUM_EXT) ? ROUTE_EXT : ROUTE_DROP;
        end
    end

    // Headers use the live decode; body flits follow the latched route
    always_comb begin
        route   = route_q;
        ext_idx = ext_idx_q;
        case (state)
            IDLE: begin
                route   = route_dec;
                ext_idx = ext_idx_dec;
            end
            DROP:    route = ROUTE_DROP;
            default: ;
        endcase
    end

    assign sel_local = (route == ROUTE_LOCAL);
    assign sel_ring  = (route == ROUTE_RING);

    for (genvar k = 0; k < NUM_EXT; k++) begin : g_sel
        assign sel_ext[k] = (route == ROUTE_EXT) && (ext_idx == SEL_BITS'(k));
    end

    assign sel = {sel_ext, sel_ring, sel_local};

    // Ready comes only from the selected port; a dropped worm is always sunk
    assign in_ring_ready = (route == ROUTE_DROP) || (|(sel & port_up_ready));
    assign accept        = in_ring.valid && in_ring_ready;

    assign port_down_ready = {out_ext_ready, out_ring_ready, out_local_ready};

    // Data and last broadcast to every port; only the selected one sees valid
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_up[p] = '{valid: in_ring.valid && sel[p],
                              last:  in_ring.last,
                              data:  in_ring.data};
        if (OUT_REG != 0) begin : g_reg
            dii_flit_reg_slice u_slice (
                .clk        (clk),
                .rst_n      (rst_n),
                .up         (port_up[p]),
                .up_ready   (port_up_ready[p]),
                .down       (port_down[p]),
                .down_ready (port_down_ready[p])
            );
        end else begin : g_wire
            assign port_down[p]     = port_up[p];
            assign port_up_ready[p] = port_down_ready[p];
        end
    end

    assign out_local = port_down[PORT_LOCAL];
    assign out_ring  = port_down[PORT_RING];
    assign out_ext   = port_down[NUM_PORTS-1:PORT_EXT0];

    // Worm tracking FSM: latch route on a multi-flit header, release on last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            route_q   <= ROUTE_RING;
            ext_idx_q <= '0;
            drop_pkt  <= 1'b0;
        end else begin
            drop_pkt <= accept && (state == IDLE) && (route_dec == ROUTE_DROP);
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!in_ring.last) begin
                            route_q   <= route_dec;
                            ext_idx_q <= ext_idx_dec;
                            state     <= (route_dec == ROUTE_DROP) ? DROP : FWD;
                        end
                    end
                    FWD, DROP: begin
                        if (in_ring.last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dii_ring_gateway_demux_n.sv
// Scoreboard bench for dii_ring_gateway_demux_n.
// dut index 0: NUM_EXT=2 OUT_REG=1, 1: NUM_EXT=3 OUT_REG=1, 2: NUM_EXT=2 OUT_REG=0.
// Port index 0 local, 1 ring, 2.. ext; destination 5 means dropped.
module tb_dii_ring_gateway_demux_n;
    import dii_package::*;

    localparam int NDUT   = 3;
    localparam int NP     = 5;
    localparam int P_LOCAL = 0;
    localparam int P_RING  = 1;
    localparam int P_EXT0  = 2;
    localparam int P_DROP  = 5;
    localparam logic [15:0] NODE_ID = 16'h0005;

    typedef struct {
        logic        last;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    int lat_of  [NDUT] = '{1, 1, 0};
    int next_of [NDUT] = '{2, 3, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n       [NDUT];
    dii_flit       in_ring     [NDUT];
    logic          in_ready    [NDUT];
    dii_flit       out_local   [NDUT];
    dii_flit       out_ring    [NDUT];
    logic          local_ready [NDUT];
    logic          ring_ready  [NDUT];
    logic [2:0]    ext_ready   [NDUT];
    logic          drop        [NDUT];
    dii_flit [1:0] ext_a;
    dii_flit [2:0] ext_b;
    dii_flit [1:0] ext_c;

    dii_ring_gateway_demux_n #(.SUBNET_BITS(6), .LOCAL_SUBNET(0), .NUM_EXT(2), .OUT_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .id(NODE_ID), .in_ring(in_ring[0]), .in_ring_ready(in_ready[0]),
        .out_local(out_local[0]), .out_local_ready(local_ready[0]),
        .out_ext(ext_a), .out_ext_ready(ext_ready[0][1:0]),
        .out_ring(out_ring[0]), .out_ring_ready(ring_ready[0]), .drop_pkt(drop[0]));

    dii_ring_gateway_demux_n #(.SUBNET_BITS(6), .LOCAL_SUBNET(0), .NUM_EXT(3), .OUT_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .id(NODE_ID), .in_ring(in_ring[1]), .in_ring_ready(in_ready[1]),
        .out_local(out_local[1]), .out_local_ready(local_ready[1]),
        .out_ext(ext_b), .out_ext_ready(ext_ready[1]),
        .out_ring(out_ring[1]), .out_ring_ready(ring_ready[1]), .drop_pkt(drop[1]));

    dii_ring_gateway_demux_n #(.SUBNET_BITS(6), .LOCAL_SUBNET(0), .NUM_EXT(2), .OUT_REG(0)) dut_c (
        .clk(clk), .rst_n(rst_n[2]), .id(NODE_ID), .in_ring(in_ring[2]), .in_ring_ready(in_ready[2]),
        .out_local(out_local[2]), .out_local_ready(local_ready[2]),
        .out_ext(ext_c), .out_ext_ready(ext_ready[2][1:0]),
        .out_ring(out_ring[2]), .out_ring_ready(ring_ready[2]), .drop_pkt(drop[2]));

    // Uniform view of every output and its ready
    dii_flit mon_out [NDUT][NP];
    logic    mon_rdy [NDUT][NP];

    always_comb begin
        for (int d = 0; d < NDUT; d++) begin
            mon_out[d][0] = out_local[d];
            mon_out[d][1] = out_ring[d];
            mon_rdy[d][0] = local_ready[d];
            mon_rdy[d][1] = ring_ready[d];
            for (int k = 0; k < 3; k++) mon_rdy[d][2+k] = ext_ready[d][k];
        end
        mon_out[0][2] = ext_a[0];
        mon_out[0][3] = ext_a[1];
        mon_out[0][4] = '0;
        mon_out[1][2] = ext_b[0];
        mon_out[1][3] = ext_b[1];
        mon_out[1][4] = ext_b[2];
        mon_out[2][2] = ext_c[0];
        mon_out[2][3] = ext_c[1];
        mon_out[2][4] = '0;
    end

    exp_t exp_q [NDUT*NP][$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   drops [NDUT] = '{default: 0};
    bit   chk_lat [NDUT] = '{default: 1'b0};
    logic [15:0] pkt [$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every transfer must match the head of that port's queue
    always begin
        @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (drop[d]) drops[d]++;
            for (int p = 0; p < NP; p++) begin
                if (mon_out[d][p].valid && mon_rdy[d][p]) begin
                    if (exp_q[d*NP+p].size() == 0) begin
                        check($sformatf("dut%0d port%0d spurious valid", d, p), 32'(mon_out[d][p].valid), 32'd0);
                    end else begin
                        mon_e = exp_q[d*NP+p].pop_front();
                        check($sformatf("dut%0d port%0d flit", d, p),
                              {15'd0, mon_out[d][p].last, mon_out[d][p].data},
                              {15'd0, mon_e.last, mon_e.data});
                        if (chk_lat[d])
                            check($sformatf("dut%0d port%0d latency", d, p), 32'(cyc - mon_e.cyc), 32'(lat_of[d]));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first n_send flits of pkt and queue them for port dst
    task automatic send_pkt(input int d, input int dst, input bit full_rate, input int n_send);
        for (int i = 0; i < n_send; i++) begin
            int waited;
            bit ok;
            exp_t e;
            waited = 0;
            ok = 1'b0;
            in_ring[d] = '{valid: 1'b1, last: (i == pkt.size() - 1), data: pkt[i]};
            while (!ok && waited < 50) begin
                @(negedge clk);
                if (in_ready[d]) begin
                    ok = 1'b1;
                    if (dst != P_DROP) begin
                        e.last = in_ring[d].last;
                        e.data = in_ring[d].data;
                        e.cyc  = cyc;
                        exp_q[d*NP+dst].push_back(e);
                    end
                end else begin
                    waited++;
                end
            end
            if (!ok) check($sformatf("dut%0d accept timeout", d), 32'(ok), 32'd1);
            if (full_rate) check($sformatf("dut%0d full-rate accept", d), 32'(waited), 32'd0);
            @(posedge clk);
            #1;
        end
        in_ring[d].valid = 1'b0;
    endtask

    task automatic check_quiet(input int d, input string tag);
        for (int p = 0; p < 2 + next_of[d]; p++)
            check($sformatf("dut%0d %s port%0d valid", d, tag, p), 32'(mon_out[d][p].valid), 32'd0);
        check($sformatf("dut%0d %s drop_pkt", d, tag), 32'(drop[d]), 32'd0);
    endtask

    task automatic flush(input int d);
        for (int p = 0; p < NP; p++) exp_q[d*NP+p].delete();
    endtask

    task automatic check_empty(input int d, input int p, input string tag);
        check($sformatf("dut%0d port%0d %s", d, p, tag), 32'(exp_q[d*NP+p].size()), 32'd0);
    endtask

    initial begin
        int base;
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d]       = 1'b0;
            in_ring[d]     = '0;
            local_ready[d] = 1'b1;
            ring_ready[d]  = 1'b1;
            ext_ready[d]   = '1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) check_quiet(d, "reset");
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
        @(posedge clk);
        #1;

        // Local hit with one-cycle latency
        chk_lat[0] = 1'b1;
        pkt = '{16'h0005, 16'hAAAA, 16'hBBBB};
        send_pkt(0, P_LOCAL, 1'b1, 3);
        idle(3);
        chk_lat[0] = 1'b0;
        check_empty(0, P_LOCAL, "local packet delivered");

        // External select: subnet 3 -> ext[1], subnet 2 -> ext[0]
        pkt = '{16'h0C00, 16'h1111};
        send_pkt(0, P_EXT0 + 1, 1'b1, 2);
        pkt = '{16'h0800, 16'h2222, 16'h3333};
        send_pkt(0, P_EXT0, 1'b1, 3);
        idle(3);
        check_empty(0, P_EXT0 + 1, "ext1 packet delivered");
        check_empty(0, P_EXT0, "ext0 packet delivered");

        // Ring pass with a 4-cycle downstream stall mid-packet
        pkt = '{16'h0012, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
        fork
            send_pkt(0, P_RING, 1'b0, 8);
            begin
                idle(2);
                ring_ready[0] = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("dut0 ring stall in_ring_ready", 32'(in_ready[0]), 32'd0);
                end
                @(posedge clk);
                #1;
                ring_ready[0] = 1'b1;
            end
        join
        idle(3);
        check_empty(0, P_RING, "ring packet delivered");

        // Drop on ext_idx 3 with NUM_EXT=3, then normal routing resumes
        base = drops[1];
        pkt = '{16'h0C00, 16'h0001, 16'h0002, 16'h0003};
        send_pkt(1, P_DROP, 1'b1, 4);
        idle(2);
        check("dut1 drop pulse count", 32'(drops[1] - base), 32'd1);
        base = drops[1];
        pkt = '{16'h0C00};
        send_pkt(1, P_DROP, 1'b1, 1);
        idle(2);
        check("dut1 single-flit drop pulse count", 32'(drops[1] - base), 32'd1);
        base = drops[1];
        pkt = '{16'h0800, 16'h4444};
        send_pkt(1, P_EXT0 + 2, 1'b1, 2);
        pkt = '{16'h0400};
        send_pkt(1, P_EXT0 + 1, 1'b1, 1);
        pkt = '{16'h0005, 16'h5555};
        send_pkt(1, P_LOCAL, 1'b1, 2);
        idle(3);
        check("dut1 no drop on routable", 32'(drops[1] - base), 32'd0);
        for (int p = 0; p < NP; p++) check_empty(1, p, "after drop test");

        // Back-to-back: held local flit must not block the following ext packet
        local_ready[0] = 1'b0;
        pkt = '{16'h0005};
        send_pkt(0, P_LOCAL, 1'b1, 1);
        pkt = '{16'h0800, 16'h1234};
        send_pkt(0, P_EXT0, 1'b1, 2);
        idle(3);
        check("dut0 b2b local held valid", 32'(out_local[0].valid), 32'd1);
        check("dut0 b2b local held data", 32'(out_local[0].data), 32'h0005);
        check_empty(0, P_EXT0, "b2b ext delivered");
        local_ready[0] = 1'b1;
        idle(2);
        check_empty(0, P_LOCAL, "b2b local released");

        // Async reset mid-packet, registered outputs
        pkt = '{16'h0005, 16'h00A1, 16'h00A2, 16'h00A3};
        send_pkt(0, P_LOCAL, 1'b1, 2);
        local_ready[0] = 1'b0;
        check("dut0 pre-reset local held", 32'(out_local[0].valid), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        flush(0);
        #1;
        check_quiet(0, "async reset");
        local_ready[0] = 1'b1;
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        pkt = '{16'h0012, 16'h00B1};
        send_pkt(0, P_RING, 1'b1, 2);
        idle(3);
        check_empty(0, P_RING, "post-reset ring");
        check_empty(0, P_LOCAL, "post-reset local");

        // Combinational outputs: zero latency and ready passthrough
        chk_lat[2] = 1'b1;
        pkt = '{16'h0005, 16'h0A0A, 16'h0B0B};
        send_pkt(2, P_LOCAL, 1'b1, 3);
        idle(1);
        chk_lat[2] = 1'b0;
        pkt = '{16'h0C00, 16'h7777};
        send_pkt(2, P_EXT0 + 1, 1'b1, 2);
        ring_ready[2] = 1'b0;
        in_ring[2] = '{valid: 1'b1, last: 1'b1, data: 16'h0012};
        @(negedge clk);
        check("dut2 comb ready low", 32'(in_ready[2]), 32'd0);
        check("dut2 comb ring valid", 32'(out_ring[2].valid), 32'd1);
        in_ring[2].valid = 1'b0;
        ring_ready[2] = 1'b1;
        #1;
        check("dut2 comb ready high", 32'(in_ready[2]), 32'd1);
        @(posedge clk);
        #1;

        // Async reset mid-packet, combinational outputs
        pkt = '{16'h0005, 16'h00C1, 16'h00C2};
        send_pkt(2, P_LOCAL, 1'b1, 2);
        #2;
        rst_n[2] = 1'b0;
        flush(2);
        #1;
        check_quiet(2, "async reset");
        @(negedge clk);
        rst_n[2] = 1'b1;
        @(posedge clk);
        #1;
        pkt = '{16'h0012, 16'h00D1};
        send_pkt(2, P_RING, 1'b1, 2);
        idle(3);

        for (int d = 0; d < NDUT; d++) begin
            local_ready[d] = 1'b1;
            ring_ready[d]  = 1'b1;
            ext_ready[d]   = '1;
        end
        idle(5);
        for (int d = 0; d < NDUT; d++)
            for (int p = 0; p < NP; p++) check_empty(d, p, "final drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
